// File: rtl/wb_unit.sv
// Writeback stage: arbitrates load responses, a one-entry ALU skid and new ALU
// results onto the register-file write port, and tracks in-flight loads in order.
module wb_unit #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] data_des,
  output logic        data_valid,
  output logic [31:0] ld_pending,
  output logic        err
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  // Load queue payload, valid bits and pointers
  logic [4:0]          lq_rd_q [LQ_DEPTH];
  logic [2:0]          lq_f3_q [LQ_DEPTH];
  logic [1:0]          lq_lo_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] lq_vld_q, lq_vld_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                skid_vld_q, skid_vld_d;
  logic [4:0]          skid_rd_q, skid_rd_d;
  logic [31:0]         skid_data_q, skid_data_d;

  logic [4:0]          rd_q, rd_d;
  logic [31:0]         data_q, data_d;
  logic                dv_q, dv_d;
  logic                err_q, err_d;

  logic                full, empty, push, pop, alu_fire;
  logic [4:0]          head_rd;
  logic [2:0]          head_f3;
  logic [1:0]          head_lo;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         fmt_data;
  logic                fmt_bad;
  logic                win_vld;
  logic [4:0]          win_rd;
  logic [31:0]         win_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CW'(LQ_DEPTH));
  assign empty     = (cnt_q == '0);
  assign ld_ready  = !full;
  assign push      = ld_issue && !full;
  assign pop       = mem_rvalid && !empty;
  assign alu_ready = !skid_vld_q && !((alu_rd != 5'd0) && ld_pending[alu_rd]);
  assign alu_fire  = alu_valid && alu_ready;

  assign rd         = rd_q;
  assign data_des   = data_q;
  assign data_valid = dv_q;
  assign err        = err_q;

  // NOTE: every signal driven in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    ld_pending = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_vld_q[i]) ld_pending[lq_rd_q[i]] = 1'b1;
    end
    ld_pending[0] = 1'b0;
  end

  assign head_rd  = lq_rd_q[rd_ptr_q];
  assign head_f3  = lq_f3_q[rd_ptr_q];
  assign head_lo  = lq_lo_q[rd_ptr_q];
  assign byte_sel = mem_rdata[{head_lo, 3'b000} +: 8];
  assign half_sel = head_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    fmt_data = '0;
    fmt_bad  = 1'b0;
    case (funct3_e'(head_f3))
      F3_LB:   fmt_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   fmt_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   fmt_data = mem_rdata;
      F3_LBU:  fmt_data = {24'd0, byte_sel};
      F3_LHU:  fmt_data = {16'd0, half_sel};
      default: fmt_bad  = 1'b1;
    endcase
  end

  // Queue bookkeeping and next-state of the write port
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    lq_vld_d = lq_vld_q;
    if (pop)  lq_vld_d[rd_ptr_q] = 1'b0;
    if (push) lq_vld_d[wr_ptr_q] = 1'b1;

    skid_vld_d  = skid_vld_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    win_vld     = 1'b0;
    win_rd      = '0;
    win_data    = '0;

    // Load response wins; an ALU result accepted alongside it is parked in the skid.
    if (pop) begin
      win_vld  = 1'b1;
      win_rd   = head_rd;
      win_data = fmt_data;
      if (alu_fire) begin
        skid_vld_d  = 1'b1;
        skid_rd_d   = alu_rd;
        skid_data_d = alu_data;
      end
    end else if (skid_vld_q) begin
      win_vld    = 1'b1;
      win_rd     = skid_rd_q;
      win_data   = skid_data_q;
      skid_vld_d = 1'b0;
    end else if (alu_fire) begin
      win_vld  = 1'b1;
      win_rd   = alu_rd;
      win_data = alu_data;
    end

    // Writes to x0 are consumed silently; the port keeps showing the last write.
    dv_d   = win_vld && (win_rd != 5'd0);
    rd_d   = dv_d ? win_rd   : rd_q;
    data_d = dv_d ? win_data : data_q;
    err_d  = err_q | (ld_issue && full) | (mem_rvalid && empty) | (pop && fmt_bad);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; the combinational blocks above use blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      lq_vld_q    <= '0;
      skid_vld_q  <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      lq_vld_q    <= lq_vld_d;
      skid_vld_q  <= skid_vld_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the queue payload is not reset; the per-entry valid bits alone decide
  // whether a slot is meaningful, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_q[wr_ptr_q] <= ld_rd;
      lq_f3_q[wr_ptr_q] <= ld_funct3;
      lq_lo_q[wr_ptr_q] <= ld_addr_lo;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases with literal expectations, then
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_wb_unit;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic [31:0] data_des;
  logic        data_valid;
  logic [31:0] ld_pending;
  logic        err;

  wb_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd(rd), .data_des(data_des), .data_valid(data_valid),
    .ld_pending(ld_pending), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ld_t;

  ld_t         m_lq[$];
  bit          m_skid_v;
  logic [4:0]  m_skid_rd;
  logic [31:0] m_skid_data;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_dv;
  bit          m_err;

  task automatic m_reset();
    m_lq.delete();
    m_skid_v    = 0;
    m_skid_rd   = '0;
    m_skid_data = '0;
    m_rd        = '0;
    m_data      = '0;
    m_dv        = 0;
    m_err       = 0;
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (m_lq[i]) if (m_lq[i].rd != 5'd0) p = p | (32'd1 << m_lq[i].rd);
    return p;
  endfunction

  function automatic bit m_alu_ready();
    logic [31:0] p = m_pending();
    return !m_skid_v && !((alu_rd != 5'd0) && p[alu_rd]);
  endfunction

  // Returns {bad, data} for a load of type f3 at byte offset lo of word w.
  function automatic logic [32:0] m_format(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
    logic [31:0] b = (w >> (8 * lo)) & 32'hFF;
    logic [31:0] h = (w >> (lo[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return {1'b0, (b >= 32'd128)   ? b + 32'hFFFFFF00 : b};
      3'd1:    return {1'b0, (h >= 32'd32768) ? h + 32'hFFFF0000 : h};
      3'd2:    return {1'b0, w};
      3'd4:    return {1'b0, b};
      3'd5:    return {1'b0, h};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic m_step();
    int          n     = m_lq.size();
    bit          full  = (n == LQ_DEPTH);
    bit          fire  = alu_valid && m_alu_ready();
    bit          resp  = mem_rvalid && (n > 0);
    bit          win   = 0;
    logic [4:0]  wrd   = '0;
    logic [31:0] wdata = '0;
    logic [32:0] f;
    if (resp) begin
      f     = m_format(m_lq[0].f3, m_lq[0].lo, mem_rdata);
      win   = 1;
      wrd   = m_lq[0].rd;
      wdata = f[31:0];
      if (f[32]) m_err = 1;
      if (fire) begin
        m_skid_v    = 1;
        m_skid_rd   = alu_rd;
        m_skid_data = alu_data;
      end
    end else if (m_skid_v) begin
      win      = 1;
      wrd      = m_skid_rd;
      wdata    = m_skid_data;
      m_skid_v = 0;
    end else if (fire) begin
      win   = 1;
      wrd   = alu_rd;
      wdata = alu_data;
    end
    m_dv = win && (wrd != 5'd0);
    if (m_dv) begin
      m_rd   = wrd;
      m_data = wdata;
    end
    if (ld_issue && full) m_err = 1;
    if (mem_rvalid && n == 0) m_err = 1;
    if (resp) void'(m_lq.pop_front());
    if (ld_issue && !full) m_lq.push_back('{ld_rd, ld_funct3, ld_addr_lo});
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_reset();
    end else begin
      check("rd",         32'(rd),         32'(m_rd));
      check("data_des",   data_des,        m_data);
      check("data_valid", 32'(data_valid), 32'(m_dv));
      check("err",        32'(err),        32'(m_err));
      check("ld_pending", ld_pending,      m_pending());
      check("ld_ready",   32'(ld_ready),   32'(m_lq.size() < LQ_DEPTH));
      check("alu_ready",  32'(alu_ready),  32'(m_alu_ready()));
      m_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid  = 0; alu_rd = '0; alu_data = '0;
    ld_issue   = 0; ld_rd  = '0; ld_funct3 = '0; ld_addr_lo = '0;
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    #1 rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic load_roundtrip(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo,
                                input logic [31:0] w, input logic [31:0] exp, input string name);
    tick(); idle();
    ld_issue = 1; ld_rd = r; ld_funct3 = f3; ld_addr_lo = lo;
    tick(); idle();
    mem_rvalid = 1; mem_rdata = w;
    tick(); idle();
    check(name, data_des, exp);
    check({name, "_rd"}, 32'(rd), 32'(r));
    check({name, "_dv"}, 32'(data_valid), 32'd1);
  endtask

  task automatic rand_phase(input int cycles, input bit legal);
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int c = 0; c < cycles; c++) begin
      tick();
      alu_valid  = ($urandom_range(0, 99) < 50);
      alu_rd     = 5'($urandom_range(0, 12));
      alu_data   = $urandom;
      ld_issue   = ($urandom_range(0, 99) < 40) && (!legal || m_lq.size() < LQ_DEPTH);
      ld_rd      = 5'($urandom_range(0, 12));
      ld_funct3  = legal ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      ld_addr_lo = 2'($urandom_range(0, 3));
      mem_rvalid = ($urandom_range(0, 99) < 40) && (!legal || m_lq.size() > 0);
      mem_rdata  = $urandom;
    end
    tick(); idle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    do_reset();

    // Reset state
    check("rst_rd",        32'(rd),         32'd0);
    check("rst_data_des",  data_des,        32'd0);
    check("rst_dv",        32'(data_valid), 32'd0);
    check("rst_err",       32'(err),        32'd0);
    check("rst_pending",   ld_pending,      32'd0);
    check("rst_ld_ready",  32'(ld_ready),   32'd1);
    check("rst_alu_ready", 32'(alu_ready),  32'd1);

    // ALU only, then a write to x0 that must not disturb the port
    tick();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick(); idle();
    check("alu_rd",   32'(rd),         32'd5);
    check("alu_data", data_des,        32'h0000_1234);
    check("alu_dv",   32'(data_valid), 32'd1);
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    tick(); idle();
    check("alu_one_cycle", 32'(data_valid), 32'd0);
    tick();
    check("x0_dv",   32'(data_valid), 32'd0);
    check("x0_rd",   32'(rd),         32'd5);
    check("x0_data", data_des,        32'h0000_1234);

    // Load formatting
    load_roundtrip(5'd6, 3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, "lb");
    load_roundtrip(5'd6, 3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080, "lbu");
    load_roundtrip(5'd6, 3'b101, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF, "lhu");
    load_roundtrip(5'd6, 3'b001, 2'd3, 32'h8001_0000, 32'hFFFF_8001, "lh_misaligned");
    load_roundtrip(5'd6, 3'b010, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw_misaligned");
    check("fmt_no_err", 32'(err), 32'd0);

    // Collision: load response and ALU in the same cycle
    tick(); idle();
    ld_issue = 1; ld_rd = 5'd7; ld_funct3 = 3'b010;
    tick(); idle();
    mem_rvalid = 1; mem_rdata = 32'hA5A5_0007;
    alu_valid = 1; alu_rd = 5'd8; alu_data = 32'h88;
    #1 check("col_alu_ready", 32'(alu_ready), 32'd1);
    tick(); idle();
    check("col_first_rd",    32'(rd),   32'd7);
    check("col_first_data",  data_des,  32'hA5A5_0007);
    tick();
    check("col_second_rd",   32'(rd),   32'd8);
    check("col_second_data", data_des,  32'h88);
    check("col_second_dv",   32'(data_valid), 32'd1);
    tick();
    check("col_done_dv",     32'(data_valid), 32'd0);

    // WAW: ALU to x9 held off until the load to x9 has been popped
    tick(); idle();
    ld_issue = 1; ld_rd = 5'd9; ld_funct3 = 3'b010;
    tick(); idle();
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    #1 check("waw_blocked", 32'(alu_ready), 32'd0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h9090_9090;
    #1 check("waw_blocked_pop", 32'(alu_ready), 32'd0);
    tick();
    mem_rvalid = 0;
    check("waw_load_rd",   32'(rd),  32'd9);
    check("waw_load_data", data_des, 32'h9090_9090);
    #1 check("waw_released", 32'(alu_ready), 32'd1);
    tick(); idle();
    check("waw_alu_data", data_des,        32'h99);
    check("waw_alu_dv",   32'(data_valid), 32'd1);

    // Reset with one load queued and the skid full
    tick(); idle();
    ld_issue = 1; ld_rd = 5'd10; ld_funct3 = 3'b010;
    tick();
    ld_rd = 5'd11;
    tick(); idle();
    mem_rvalid = 1; mem_rdata = 32'h1010_1010;
    alu_valid = 1; alu_rd = 5'd12; alu_data = 32'h12;
    tick(); idle();
    check("pre_rst_dv", 32'(data_valid), 32'd1);
    #1 check("pre_rst_skid_full", 32'(alu_ready), 32'd0);
    check("pre_rst_pending", ld_pending, 32'd1 << 11);
    #1 rst = 1;
    #1;
    check("async_rst_rd",      32'(rd),         32'd0);
    check("async_rst_data",    data_des,        32'd0);
    check("async_rst_dv",      32'(data_valid), 32'd0);
    check("async_rst_pending", ld_pending,      32'd0);
    check("async_rst_ready",   32'(alu_ready),  32'd1);
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_write", 32'(data_valid), 32'd0);
    end
    mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    tick(); idle();
    check("stray_resp_err", 32'(err),        32'd1);
    check("stray_resp_dv",  32'(data_valid), 32'd0);

    // Illegal funct3: zero data, write still happens, err raised
    do_reset();
    load_roundtrip(5'd13, 3'b011, 2'd1, 32'hFFFF_FFFF, 32'd0, "bad_f3");
    check("bad_f3_err", 32'(err), 32'd1);

    // Queue full
    do_reset();
    tick();
    ld_issue = 1; ld_rd = 5'd3; ld_funct3 = 3'b010;
    tick();
    ld_rd = 5'd4;
    tick(); idle();
    #1 check("full_ld_ready", 32'(ld_ready), 32'd0);
    check("full_pending", ld_pending, (32'd1 << 3) | (32'd1 << 4));
    check("full_no_err",  32'(err),   32'd0);
    ld_issue = 1; ld_rd = 5'd5;
    tick(); idle();
    check("overflow_err",     32'(err),   32'd1);
    check("overflow_pending", ld_pending, (32'd1 << 3) | (32'd1 << 4));
    mem_rvalid = 1; mem_rdata = 32'h3;
    tick(); idle();
    #1 check("drain1_pending", ld_pending, 32'd1 << 4);
    check("drain1_rd", 32'(rd), 32'd3);
    mem_rvalid = 1; mem_rdata = 32'h4;
    tick(); idle();
    #1 check("drain2_pending", ld_pending, 32'd0);
    check("drain2_rd", 32'(rd), 32'd4);

    // Randomized traffic against the model
    do_reset();
    rand_phase(800, 1'b1);
    do_reset();
    rand_phase(800, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
